// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and constants shared by the UART receiver and transmitter.
//   DATA_BITS          : payload bits per character
//   OVERSAMPLE_DEFAULT : default number of sample strobes per bit period
//   rx_state_e         : receiver FSM states
//   tx_state_e         : transmitter FSM states
//   tx_req_t           : transmit request (byte plus valid flag)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS          = 8;
    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic                 valid;
        logic [DATA_BITS-1:0] data;
    } tx_req_t;

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk     in  system clock, rising edge
//   nReset  in  asynchronous active-low reset; both flops load RESET_VAL
//   d       in  asynchronous input
//   q       out synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic nReset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_en.sv
// -----------------------------------------------------------------------------
// uart_rx_en
// UART receiver (8 data bits, no parity, one stop bit) driven by an external
// sample strobe running at OVERSAMPLE x baud. The FSM only advances on en.
// Ports:
//   clk     in  system clock, rising edge
//   nReset  in  asynchronous active-low reset
//   en      in  sample strobe, OVERSAMPLE per bit period
//   in      in  serial line, idle high, asynchronous to clk
//   data    out last correctly framed byte (LSB received first)
//   done    out one-clk pulse: new byte on data
//   err     out one-clk pulse: framing error (stop bit sampled low)
//   busy    out high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx_en
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       en,
    input  logic       in,
    output logic [7:0] data,
    output logic       done,
    output logic       err,
    output logic       busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e            state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 prev_s_q,  prev_s_d;
    logic                 done_q,    done_d;
    logic                 err_q,     err_d;
    logic                 busy_q,    busy_d;

    // Resets high so a released reset on an idle line is not seen as a start edge.
    uart_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk    (clk),
        .nReset (nReset),
        .d      (in),
        .q      (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        prev_s_d  = prev_s_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (en) begin
            prev_s_d = rx_s;

            unique case (state_q)
                IDLE: begin
                    // Only a 1->0 transition starts a frame; a line stuck low
                    // (break) never re-triggers.
                    if (prev_s_q && !rx_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end

                START: begin
                    // Re-check the line half a bit after the edge to reject glitches.
                    if (cnt_q == CNT_MID) begin
                        cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        // Counting starts at mid start bit, so this is mid data bit.
                        cnt_d     = '0;
                        shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        if (rx_s) begin
                            data_d = shift_q;
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            prev_s_q  <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            prev_s_q  <= prev_s_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign data = data_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule
